// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer-width derivation and Gray/binary conversion shared by both FIFO pointer controllers.
package fifo_pkg;
  localparam int MAX_W = 32;
  function automatic int ptr_w(input int addr_w);
    return addr_w + 1;
  endfunction
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  // Prefix XOR from the MSB down; callers zero-extend, so unused upper bits stay 0.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/fifo_wr_ptr_ctrl_if.sv
// fifo_wr_ptr_ctrl_if: producer handshake, memory write port and pointer exchange of the write-side controller.
interface fifo_wr_ptr_ctrl_if import fifo_pkg::*; #(parameter int ADDR_WIDTH = 4);
  localparam int PTR_W = ptr_w(ADDR_WIDTH);
  logic wr_en, wr_accept, full, almost_full, wr_overflow;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [PTR_W-1:0] rd_gray_async, wr_gray, rd_gray_sync, wr_level;
  modport master(output wr_en, rd_gray_async,
                 input wr_accept, wr_addr, wr_gray, rd_gray_sync, full, almost_full, wr_level, wr_overflow);
  modport slave(input wr_en, rd_gray_async,
                output wr_accept, wr_addr, wr_gray, rd_gray_sync, full, almost_full, wr_level, wr_overflow);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: plain two-flop synchronizer, no logic between the stages.
module sync_2ff #(parameter int WIDTH = 1) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] meta_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      meta_q <= '0;
      q      <= '0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// fifo_wr_ptr_ctrl: write-domain pointer controller with registered full, almost-full, level and overflow.
module fifo_wr_ptr_ctrl import fifo_pkg::*; #(
  parameter int ADDR_WIDTH         = 4,
  parameter int ALMOST_FULL_THRESH = 12
) (
  input logic                wr_clk,
  input logic                wr_rst_n,
  fifo_wr_ptr_ctrl_if.slave  bus
);
  localparam int PTR_W = ptr_w(ADDR_WIDTH);
  logic [PTR_W-1:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d, wr_level_q, wr_level_d;
  logic [PTR_W-1:0] rd_gray_sync, rd_bin_sync;
  logic full_q, full_d, almost_full_q, almost_full_d, wr_overflow_q, wr_overflow_d, accept;
  sync_2ff #(.WIDTH(PTR_W)) u_rd_sync (
    .clk  (wr_clk),
    .rst_n(wr_rst_n),
    .d    (bus.rd_gray_async),
    .q    (rd_gray_sync)
  );
  // Full and level use the pre-edge synchronized read pointer, so a stale value only over-reports.
  always_comb begin
    accept        = bus.wr_en & ~full_q & wr_rst_n;
    wr_bin_d      = wr_bin_q + PTR_W'(accept);
    wr_gray_d     = PTR_W'(bin2gray(MAX_W'(wr_bin_d)));
    rd_bin_sync   = PTR_W'(gray2bin(MAX_W'(rd_gray_sync)));
    full_d        = wr_gray_d == {~rd_gray_sync[PTR_W-1 -: 2], rd_gray_sync[PTR_W-3:0]};
    wr_level_d    = wr_bin_d - rd_bin_sync;
    almost_full_d = wr_level_d >= PTR_W'(ALMOST_FULL_THRESH);
    wr_overflow_d = bus.wr_en & full_q;
  end
  always_ff @(posedge wr_clk or negedge wr_rst_n)
    if (!wr_rst_n) begin
      wr_bin_q      <= '0;
      wr_gray_q     <= '0;
      wr_level_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      wr_overflow_q <= 1'b0;
    end else begin
      wr_bin_q      <= wr_bin_d;
      wr_gray_q     <= wr_gray_d;
      wr_level_q    <= wr_level_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      wr_overflow_q <= wr_overflow_d;
    end
  assign bus.wr_accept    = accept;
  assign bus.wr_addr      = wr_bin_q[ADDR_WIDTH-1:0];
  assign bus.wr_gray      = wr_gray_q;
  assign bus.rd_gray_sync = rd_gray_sync;
  assign bus.full         = full_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.wr_level     = wr_level_q;
  assign bus.wr_overflow  = wr_overflow_q;
endmodule
